// File: rtl/cordic_iter_seq_if.sv
// cordic_iter_seq_if: handshake, mux select and result bus between the CORDIC sequencer and its neighbours
interface cordic_iter_seq_if #(
  parameter int W  = 32,
  parameter int CW = 5
);
  logic          beg_fsm;
  logic          ack_fsm;
  logic [W-1:0]  mux_data;
  logic          sel_mux;
  logic [CW-1:0] iter_cnt;
  logic [W-1:0]  data_q;
  logic          ready;
  logic          done;
  modport master (
    output beg_fsm, ack_fsm, mux_data,
    input  sel_mux, iter_cnt, data_q, ready, done
  );
  modport slave (
    input  beg_fsm, ack_fsm, mux_data,
    output sel_mux, iter_cnt, data_q, ready, done
  );
endinterface

// File: rtl/cordic_iter_seq.sv
// cordic_iter_seq: steers the operand mux, latches each micro-rotation result and hands the final value downstream
module cordic_iter_seq #(
  parameter int W      = 32,
  parameter int N_ITER = 16,
  parameter int CW     = 5
) (
  input  logic           clk,
  input  logic           rst,
  cordic_iter_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;
  localparam logic [CW-1:0] LAST = CW'(N_ITER - 1);
  state_t        r_state;
  logic [W-1:0]  r_data;
  logic [CW-1:0] r_cnt;
  // state, result register and iteration index; DONE holds everything until acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.beg_fsm) r_state <= LOAD;
        end
        LOAD: begin
          r_data  <= bus.mux_data;
          r_cnt   <= '0;
          r_state <= ITER;
        end
        ITER: begin
          r_data <= bus.mux_data;
          if (r_cnt == LAST) r_state <= DONE;
          else r_cnt <= r_cnt + 1'b1;
        end
        DONE: if (bus.ack_fsm) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.sel_mux  = r_state == ITER;
  assign bus.ready    = r_state == IDLE;
  assign bus.done     = r_state == DONE;
  assign bus.data_q   = r_data;
  assign bus.iter_cnt = r_cnt;
endmodule

// File: tb/tb_cordic_iter_seq.sv
// tb_cordic_iter_seq: directed checks of the sequencer against a mux model (ch0 = 5, ch1 = data_q + 1)
module tb_cordic_iter_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rand_en = 1'b0;
  logic [31:0] rnd = '0;
  int total = 0;
  int bad = 0;
  int lat;
  logic seen_done;
  cordic_iter_seq_if #(.W(32), .CW(5)) bus ();
  cordic_iter_seq_if #(.W(32), .CW(5)) bus1 ();
  cordic_iter_seq #(.W(32), .N_ITER(16), .CW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  cordic_iter_seq #(.W(32), .N_ITER(1), .CW(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  always #5 clk = ~clk;
  // upstream 2:1 mux model
  always_comb bus.mux_data  = rand_en ? rnd : (bus.sel_mux ? bus.data_q + 32'd1 : 32'h5);
  always_comb bus1.mux_data = rand_en ? rnd : (bus1.sel_mux ? bus1.data_q + 32'd1 : 32'h5);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // pulse beg_fsm after the current edge, optionally poke beg again at a given iter_cnt, wait for done
  task automatic run_op(input int poke, output int n);
    bus.beg_fsm = 1'b1;
    step();
    bus.beg_fsm = 1'b0;
    n = 1;
    while (!bus.done && n < 40) begin
      bus.beg_fsm = (poke >= 0 && bus.sel_mux && bus.iter_cnt == 5'(poke));
      step();
      n++;
    end
    bus.beg_fsm = 1'b0;
  endtask
  initial begin
    bus.beg_fsm = 1'b0; bus.ack_fsm = 1'b0;
    bus1.beg_fsm = 1'b0; bus1.ack_fsm = 1'b0;
    rand_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rnd = $urandom;
      bus.beg_fsm = 1'($urandom); bus.ack_fsm = 1'($urandom);
      bus1.beg_fsm = 1'($urandom); bus1.ack_fsm = 1'($urandom);
      step();
    end
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sel", 32'(bus.sel_mux), 32'd0);
    chk("rst_data", bus.data_q, 32'd0);
    chk("rst_cnt", 32'(bus.iter_cnt), 32'd0);
    rst = 1'b0; rand_en = 1'b0;
    bus.beg_fsm = 1'b0; bus.ack_fsm = 1'b0;
    bus1.beg_fsm = 1'b0; bus1.ack_fsm = 1'b0;
    step();
    chk("idle_ready", 32'(bus.ready), 32'd1);
    bus.beg_fsm = 1'b1;
    step();
    bus.beg_fsm = 1'b0;
    chk("load_sel", 32'(bus.sel_mux), 32'd0);
    chk("load_ready", 32'(bus.ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("iter_sel", 32'(bus.sel_mux), 32'd1);
      chk("iter_cnt", 32'(bus.iter_cnt), 32'(i));
      chk("iter_data", bus.data_q, 32'(5 + i));
      chk("iter_done", 32'(bus.done), 32'd0);
    end
    step();
    chk("run_done", 32'(bus.done), 32'd1);
    chk("run_data", bus.data_q, 32'h15);
    chk("run_cnt", 32'(bus.iter_cnt), 32'd15);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_done", 32'(bus.done), 32'd1);
      chk("hold_data", bus.data_q, 32'h15);
    end
    bus.ack_fsm = 1'b1;
    step();
    bus.ack_fsm = 1'b0;
    chk("ack_ready", 32'(bus.ready), 32'd1);
    chk("ack_done", 32'(bus.done), 32'd0);
    run_op(4, lat);
    chk("busy_lat", 32'(lat), 32'd18);
    chk("busy_data", bus.data_q, 32'h15);
    step(); step();
    chk("busy_noqueue", 32'(bus.done), 32'd1);
    bus.ack_fsm = 1'b1;
    step();
    bus.ack_fsm = 1'b0;
    step();
    chk("busy_idle", 32'(bus.ready), 32'd1);
    chk("busy_sel", 32'(bus.sel_mux), 32'd0);
    run_op(-1, lat);
    chk("both_lat", 32'(lat), 32'd18);
    bus.beg_fsm = 1'b1; bus.ack_fsm = 1'b1;
    step();
    bus.beg_fsm = 1'b0; bus.ack_fsm = 1'b0;
    chk("both_ready", 32'(bus.ready), 32'd1);
    chk("both_sel", 32'(bus.sel_mux), 32'd0);
    step();
    chk("both_noload", 32'(bus.ready), 32'd1);
    bus.beg_fsm = 1'b1;
    step();
    bus.beg_fsm = 1'b0;
    lat = 0;
    while (!(bus.sel_mux && bus.iter_cnt == 5'd7) && lat < 40) begin
      step();
      lat++;
    end
    chk("mid_reach7", 32'(bus.iter_cnt), 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_ready", 32'(bus.ready), 32'd1);
    chk("mid_data", bus.data_q, 32'd0);
    chk("mid_cnt", 32'(bus.iter_cnt), 32'd0);
    seen_done = bus.done;
    for (int i = 0; i < 20; i++) begin
      step();
      seen_done |= bus.done;
    end
    chk("mid_nodone", 32'(seen_done), 32'd0);
    bus1.beg_fsm = 1'b1;
    step();
    bus1.beg_fsm = 1'b0;
    chk("n1_load", 32'(bus1.done), 32'd0);
    step();
    chk("n1_sel", 32'(bus1.sel_mux), 32'd1);
    chk("n1_done_early", 32'(bus1.done), 32'd0);
    step();
    chk("n1_done", 32'(bus1.done), 32'd1);
    chk("n1_data", bus1.data_q, 32'h6);
    chk("n1_cnt", 32'(bus1.iter_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
